// File: rtl/res_stream_tx.sv
// res_stream_tx: reads RES_RAM words 0 .. 2^RES_depth_bits-1 and sends them out as one
// AXI4-Stream packet with TLAST on the final word.
//
// Ports:
//   clk, reset         single clock, synchronous active-high reset
//   Start              begin one packet (sampled only while idle)
//   Done               one-cycle pulse after the TLAST beat is accepted
//   RES_read_en        RES_RAM read enable (RAM samples it on the next rising edge)
//   RES_read_address   RES_RAM read address
//   RES_read_data_out  RES_RAM read data, valid the cycle after the read is sampled
//   M_AXIS_*           stream master; TDATA is the RAM word zero-extended
//
// Reads are issued against a 2-entry output FIFO using a credit count of
// (FIFO occupancy + read in flight), so the FIFO can never overflow under backpressure.
module res_stream_tx #(
  parameter int unsigned width              = 8,
  parameter int unsigned RES_depth_bits     = 1,
  parameter int unsigned C_AXIS_TDATA_WIDTH = 32
) (
  input  logic                                                 clk,
  input  logic                                                 reset,
  input  logic                                                 Start,
  output logic                                                 Done,
  output logic                                                 RES_read_en,
  output logic [(RES_depth_bits > 0 ? RES_depth_bits : 1)-1:0] RES_read_address,
  input  logic [width-1:0]                                     RES_read_data_out,
  output logic                                                 M_AXIS_TVALID,
  input  logic                                                 M_AXIS_TREADY,
  output logic [C_AXIS_TDATA_WIDTH-1:0]                        M_AXIS_TDATA,
  output logic                                                 M_AXIS_TLAST
);

  // A zero-bit address is not representable; a depth of one word uses a 1-bit address of 0.
  localparam int unsigned AddrW    = (RES_depth_bits > 0) ? RES_depth_bits : 1;
  localparam int unsigned CntW     = RES_depth_bits + 1;
  localparam int unsigned NumWords = 1 << RES_depth_bits;
  localparam logic [CntW-1:0] NumCnt  = CntW'(NumWords);
  localparam logic [CntW-1:0] LastCnt = CntW'(NumWords - 1);

  typedef enum logic [1:0] {StIdle, StSend, StDone} state_e;

  state_e                  state_q, state_d;
  logic                    armed_q, armed_d;
  logic [CntW-1:0]         rd_idx_q, rd_idx_d;
  logic [CntW-1:0]         tx_idx_q, tx_idx_d;
  logic [AddrW-1:0]        addr_q, addr_d;
  logic                    infl_q, infl_d;
  logic                    infl_last_q, infl_last_d;
  logic [1:0][width-1:0]   fifo_data_q, fifo_data_d;
  logic [1:0]              fifo_last_q, fifo_last_d;
  logic                    wr_ptr_q, wr_ptr_d;
  logic                    rd_ptr_q, rd_ptr_d;
  logic [1:0]              count_q, count_d;

  logic       fifo_valid;
  logic       pop;
  logic       push;
  logic       issue;
  logic [2:0] credits;

  assign fifo_valid = (count_q != 2'd0);
  assign pop        = fifo_valid & M_AXIS_TREADY;
  assign push       = infl_q;
  assign credits    = {1'b0, count_q} + {2'b00, infl_q};

  // armed_q delays the first read by one cycle after entering SEND so the first word
  // appears three cycles after Start is sampled. A read may be issued while a word leaves
  // the FIFO this cycle, which keeps the stream at one beat per cycle.
  assign issue = (state_q == StSend) && armed_q && (rd_idx_q < NumCnt) &&
                 (credits < (3'd2 + {2'b00, pop}));

  always_comb begin
    state_d     = state_q;
    armed_d     = (state_q == StSend);
    rd_idx_d    = rd_idx_q;
    tx_idx_d    = tx_idx_q;
    addr_d      = addr_q;
    infl_d      = issue;
    infl_last_d = infl_last_q;
    fifo_data_d = fifo_data_q;
    fifo_last_d = fifo_last_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;

    unique case (state_q)
      StIdle: begin
        if (Start) begin
          state_d  = StSend;
          rd_idx_d = '0;
          tx_idx_d = '0;
        end
      end
      StSend: begin
        // The handshake on beat N-1 is the TLAST beat.
        if (pop && (tx_idx_q == LastCnt)) state_d = StDone;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    if (issue) begin
      rd_idx_d    = rd_idx_q + 1'b1;
      addr_d      = rd_idx_q[AddrW-1:0];
      infl_last_d = (rd_idx_q == LastCnt);
    end

    if (push) begin
      fifo_data_d[wr_ptr_q] = RES_read_data_out;
      fifo_last_d[wr_ptr_q] = infl_last_q;
      wr_ptr_d              = ~wr_ptr_q;
    end

    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
      tx_idx_d = tx_idx_q + 1'b1;
    end

    count_d = count_q + {1'b0, push} - {1'b0, pop};
  end

  always_comb begin
    M_AXIS_TDATA             = '0;
    M_AXIS_TDATA[width-1:0]  = fifo_data_q[rd_ptr_q];
  end

  assign M_AXIS_TVALID    = fifo_valid;
  assign M_AXIS_TLAST     = fifo_valid & fifo_last_q[rd_ptr_q];
  assign RES_read_en      = issue;
  assign RES_read_address = issue ? rd_idx_q[AddrW-1:0] : addr_q;
  assign Done             = (state_q == StDone);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      armed_q     <= 1'b0;
      rd_idx_q    <= '0;
      tx_idx_q    <= '0;
      addr_q      <= '0;
      infl_q      <= 1'b0;
      infl_last_q <= 1'b0;
      fifo_data_q <= '0;
      fifo_last_q <= '0;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      count_q     <= 2'd0;
    end else begin
      state_q     <= state_d;
      armed_q     <= armed_d;
      rd_idx_q    <= rd_idx_d;
      tx_idx_q    <= tx_idx_d;
      addr_q      <= addr_d;
      infl_q      <= infl_d;
      infl_last_q <= infl_last_d;
      fifo_data_q <= fifo_data_d;
      fifo_last_q <= fifo_last_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
    end
  end

endmodule

// File: tb/tb_res_stream_tx.sv
// Bench for res_stream_tx: a 4-word instance and a 1-word instance, each fed by a small
// synchronous-read RAM model. Each table row gives the inputs for one cycle and the
// outputs expected during that cycle (checked after the inputs settle, before the edge).
module tb_res_stream_tx;

  logic        clk;
  logic        reset;

  logic        start_a, rdy_a, done_a, en_a, valid_a, last_a;
  logic [1:0]  addr_a;
  logic [7:0]  rdata_a;
  logic [31:0] data_a;

  logic        start_b, rdy_b, done_b, en_b, valid_b, last_b;
  logic [0:0]  addr_b;
  logic [7:0]  rdata_b;
  logic [31:0] data_b;

  logic [7:0]  ram_a [4];
  logic [7:0]  ram_b [1];

  int checks;
  int failures;
  int hs_count;
  int done_count;

  res_stream_tx #(
    .width              (8),
    .RES_depth_bits     (2),
    .C_AXIS_TDATA_WIDTH (32)
  ) u_dut_a (
    .clk               (clk),
    .reset             (reset),
    .Start             (start_a),
    .Done              (done_a),
    .RES_read_en       (en_a),
    .RES_read_address  (addr_a),
    .RES_read_data_out (rdata_a),
    .M_AXIS_TVALID     (valid_a),
    .M_AXIS_TREADY     (rdy_a),
    .M_AXIS_TDATA      (data_a),
    .M_AXIS_TLAST      (last_a)
  );

  res_stream_tx #(
    .width              (8),
    .RES_depth_bits     (0),
    .C_AXIS_TDATA_WIDTH (32)
  ) u_dut_b (
    .clk               (clk),
    .reset             (reset),
    .Start             (start_b),
    .Done              (done_b),
    .RES_read_en       (en_b),
    .RES_read_address  (addr_b),
    .RES_read_data_out (rdata_b),
    .M_AXIS_TVALID     (valid_b),
    .M_AXIS_TREADY     (rdy_b),
    .M_AXIS_TDATA      (data_b),
    .M_AXIS_TLAST      (last_b)
  );

  // 1-cycle synchronous-read RAMs
  always @(posedge clk) begin
    if (en_a) rdata_a <= ram_a[addr_a];
    if (en_b) rdata_b <= ram_b[addr_b];
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  typedef struct {
    bit sel;   // 0: 4-word instance, 1: 1-word instance
    bit rst;
    bit st;
    bit rdy;
    bit vld;
    int data;  // -1: not checked
    bit last;
    bit done;
    bit en;
    int addr;  // -1: not checked
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(bit sel, bit rst, bit st, bit rdy, bit vld, int data, bit last,
                              bit done, bit en, int addr);
    vec_t v;
    v.sel = sel; v.rst = rst; v.st = st; v.rdy = rdy; v.vld = vld;
    v.data = data; v.last = last; v.done = done; v.en = en; v.addr = addr;
    return v;
  endfunction

  task automatic cmp(input string name, input int row, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s row %0d: got 0x%0h expected 0x%0h", name, row, act, exp);
    end
  endtask

  initial begin
    vec_t        v;
    logic        a_vld, a_last, a_done, a_en;
    logic [31:0] a_data, a_addr;

    checks = 0; failures = 0; hs_count = 0; done_count = 0;
    ram_a[0] = 8'h11; ram_a[1] = 8'h22; ram_a[2] = 8'h33; ram_a[3] = 8'h44;
    ram_b[0] = 8'hFF;

    //            sel rst st rdy vld data  last done en addr
    // Reset held with Start=1, then released with Start=0
    tbl.push_back(mk(0, 1, 1, 1, 0, 0,    0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 1, 1, 0, 0,    0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 0, 0,    0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 0, 0,    0, 0, 0, 0));
    // Full-rate packet
    tbl.push_back(mk(0, 0, 1, 1, 0, -1,   0, 0, 0, -1));
    tbl.push_back(mk(0, 0, 0, 1, 0, -1,   0, 0, 0, -1));
    tbl.push_back(mk(0, 0, 0, 1, 0, -1,   0, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 1, 0, -1,   0, 0, 1, 1));
    tbl.push_back(mk(0, 0, 0, 1, 1, 'h11, 0, 0, 1, 2));
    tbl.push_back(mk(0, 0, 0, 1, 1, 'h22, 0, 0, 1, 3));
    tbl.push_back(mk(0, 0, 0, 1, 1, 'h33, 0, 0, 0, -1));
    tbl.push_back(mk(0, 0, 0, 1, 1, 'h44, 1, 0, 0, -1));
    tbl.push_back(mk(0, 0, 0, 1, 0, -1,   0, 1, 0, -1));
    // Backpressure: TREADY 1,0,0,1,0,1,1 from the first valid beat
    tbl.push_back(mk(0, 0, 1, 1, 0, -1,   0, 0, 0, -1));
    tbl.push_back(mk(0, 0, 0, 1, 0, -1,   0, 0, 0, -1));
    tbl.push_back(mk(0, 0, 0, 1, 0, -1,   0, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 1, 0, -1,   0, 0, 1, 1));
    tbl.push_back(mk(0, 0, 0, 1, 1, 'h11, 0, 0, 1, 2));
    tbl.push_back(mk(0, 0, 0, 0, 1, 'h22, 0, 0, 0, -1));
    tbl.push_back(mk(0, 0, 0, 0, 1, 'h22, 0, 0, 0, -1));
    tbl.push_back(mk(0, 0, 0, 1, 1, 'h22, 0, 0, 1, 3));
    tbl.push_back(mk(0, 0, 0, 0, 1, 'h33, 0, 0, 0, -1));
    tbl.push_back(mk(0, 0, 0, 1, 1, 'h33, 0, 0, 0, -1));
    tbl.push_back(mk(0, 0, 0, 1, 1, 'h44, 1, 0, 0, -1));
    tbl.push_back(mk(0, 0, 0, 1, 0, -1,   0, 1, 0, -1));
    // Start pulsed mid-packet (ignored), then held high through DONE
    tbl.push_back(mk(0, 0, 1, 1, 0, -1,   0, 0, 0, -1));
    tbl.push_back(mk(0, 0, 0, 1, 0, -1,   0, 0, 0, -1));
    tbl.push_back(mk(0, 0, 0, 1, 0, -1,   0, 0, 1, 0));
    tbl.push_back(mk(0, 0, 1, 1, 0, -1,   0, 0, 1, 1));
    tbl.push_back(mk(0, 0, 1, 1, 1, 'h11, 0, 0, 1, 2));
    tbl.push_back(mk(0, 0, 0, 1, 1, 'h22, 0, 0, 1, 3));
    tbl.push_back(mk(0, 0, 1, 1, 1, 'h33, 0, 0, 0, -1));
    tbl.push_back(mk(0, 0, 1, 1, 1, 'h44, 1, 0, 0, -1));
    tbl.push_back(mk(0, 0, 1, 1, 0, -1,   0, 1, 0, -1));
    tbl.push_back(mk(0, 0, 1, 1, 0, -1,   0, 0, 0, -1));
    // Second packet starts right after DONE; reset after beat 1
    tbl.push_back(mk(0, 0, 0, 1, 0, -1,   0, 0, 0, -1));
    tbl.push_back(mk(0, 0, 0, 1, 0, -1,   0, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 1, 0, -1,   0, 0, 1, 1));
    tbl.push_back(mk(0, 0, 0, 1, 1, 'h11, 0, 0, 1, 2));
    tbl.push_back(mk(0, 0, 0, 1, 1, 'h22, 0, 0, 1, 3));
    tbl.push_back(mk(0, 1, 0, 0, 1, 'h33, 0, 0, 0, -1));
    tbl.push_back(mk(0, 0, 0, 1, 0, 0,    0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 0, 0,    0, 0, 0, 0));
    // Fresh packet after the reset starts from address 0
    tbl.push_back(mk(0, 0, 1, 1, 0, -1,   0, 0, 0, -1));
    tbl.push_back(mk(0, 0, 0, 1, 0, -1,   0, 0, 0, -1));
    tbl.push_back(mk(0, 0, 0, 1, 0, -1,   0, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 1, 0, -1,   0, 0, 1, 1));
    tbl.push_back(mk(0, 0, 0, 1, 1, 'h11, 0, 0, 1, 2));
    tbl.push_back(mk(0, 0, 0, 1, 1, 'h22, 0, 0, 1, 3));
    tbl.push_back(mk(0, 0, 0, 1, 1, 'h33, 0, 0, 0, -1));
    tbl.push_back(mk(0, 0, 0, 1, 1, 'h44, 1, 0, 0, -1));
    tbl.push_back(mk(0, 0, 0, 1, 0, -1,   0, 1, 0, -1));
    tbl.push_back(mk(0, 0, 0, 1, 0, -1,   0, 0, 0, -1));
    // One-word instance: single beat 0x000000FF with TLAST, then Done
    tbl.push_back(mk(1, 0, 1, 0, 0, -1,   0, 0, 0, -1));
    tbl.push_back(mk(1, 0, 0, 0, 0, -1,   0, 0, 0, -1));
    tbl.push_back(mk(1, 0, 0, 0, 0, -1,   0, 0, 1, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, -1,   0, 0, 0, -1));
    tbl.push_back(mk(1, 0, 0, 1, 1, 'hFF, 1, 0, 0, -1));
    tbl.push_back(mk(1, 0, 0, 1, 0, -1,   0, 1, 0, -1));
    tbl.push_back(mk(1, 0, 0, 1, 0, -1,   0, 0, 0, -1));

    // One reset edge before the table; the first two table rows add two more.
    reset = 1'b1; start_a = 1'b1; rdy_a = 1'b1; start_b = 1'b0; rdy_b = 1'b0;
    @(posedge clk);

    for (int i = 0; i < tbl.size(); i++) begin
      v = tbl[i];
      @(negedge clk);
      reset   = v.rst;
      start_a = v.sel ? 1'b0 : v.st;
      rdy_a   = v.sel ? 1'b1 : v.rdy;
      start_b = v.sel ? v.st : 1'b0;
      rdy_b   = v.sel ? v.rdy : 1'b0;
      #1;
      if (!v.sel) begin
        a_vld = valid_a; a_data = data_a; a_last = last_a; a_done = done_a;
        a_en = en_a; a_addr = {30'd0, addr_a};
        if (valid_a && rdy_a) hs_count++;
        if (done_a) done_count++;
      end else begin
        a_vld = valid_b; a_data = data_b; a_last = last_b; a_done = done_b;
        a_en = en_b; a_addr = {31'd0, addr_b};
      end
      cmp("tvalid", i, {31'd0, a_vld}, {31'd0, v.vld});
      if (v.data >= 0) cmp("tdata", i, a_data, v.data);
      cmp("tlast", i, {31'd0, a_last}, {31'd0, v.last});
      cmp("done", i, {31'd0, a_done}, {31'd0, v.done});
      cmp("read_en", i, {31'd0, a_en}, {31'd0, v.en});
      if (v.addr >= 0) cmp("read_addr", i, a_addr, v.addr);
    end

    // 4 + 4 + 4 + 2 (aborted) + 4 beats; four completed packets
    cmp("handshake_total", -1, hs_count, 18);
    cmp("done_total", -1, done_count, 4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
